// File: rtl/tin_lane_pack_pkg.sv
// ============================================================================
// Module   : tin_lane_pack_pkg
// Brief    : Shared constants and lane-slice helper for the Tin lane packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// CNN-wide defines; a project-level include may already provide them.
`ifndef Tin
`define Tin 8
`endif
`ifndef log2_Tin
`define log2_Tin 3
`endif

package tin_lane_pack_pkg;

    localparam int c_TIN_DEFAULT          = `Tin;
    localparam int c_LOG2_TIN_DEFAULT     = `log2_Tin;
    localparam int c_DATA_WIDTH_DEFAULT   = 16;
    localparam int c_FLUSH_CYCLES_DEFAULT = 16;

    // Low bit of lane j inside a packed word.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tin_pack_out_reg.sv
// ============================================================================
// Module   : tin_pack_out_reg
// Brief    : Output holding register for the lane packer (valid/ready slot).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tin_pack_out_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int TIN        = 8,
    parameter int LOG2_TIN   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [DATA_WIDTH*TIN-1:0]  load_dat,
    input  logic [LOG2_TIN:0]          load_cnt,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [DATA_WIDTH*TIN-1:0]  m_dat,
    output logic [LOG2_TIN:0]          m_cnt,
    output logic                       s_ready
);

    logic                      r_valid;
    logic [DATA_WIDTH*TIN-1:0] r_dat;
    logic [LOG2_TIN:0]         r_cnt;

    // The slot can take a new word when empty or being drained this cycle.
    assign s_ready = !r_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dat   <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_dat   <= load_dat;
            r_cnt   <= load_cnt;
        end else if (r_valid && m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign m_valid = r_valid;
    assign m_dat   = r_dat;
    assign m_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/tin_lane_pack.sv
// ============================================================================
// Module   : tin_lane_pack
// Brief    : Serial-to-parallel packer gathering TIN elements into one word;
//            optional idle flush enabled by TIN_PACK_FLUSH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tin_lane_pack
    import tin_lane_pack_pkg::*;
#(
    parameter int DATA_WIDTH   = c_DATA_WIDTH_DEFAULT,
    parameter int TIN          = c_TIN_DEFAULT,
    parameter int LOG2_TIN     = c_LOG2_TIN_DEFAULT,
    parameter int FLUSH_CYCLES = c_FLUSH_CYCLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_WIDTH-1:0]      s_dat,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*TIN-1:0]  m_dat,
    output logic [LOG2_TIN:0]          m_cnt
);

    localparam int c_W = DATA_WIDTH * TIN;

    if (TIN < 2 || (1 << LOG2_TIN) != TIN || FLUSH_CYCLES < 1) begin : g_bad_params
        $error("tin_lane_pack: inconsistent TIN/LOG2_TIN/FLUSH_CYCLES");
    end

    logic [c_W-1:0]      r_fill;
    logic [LOG2_TIN-1:0] r_cnt;

    logic                w_in_beat;
    logic                w_complete;
    logic                w_flush;
    logic                w_load;
    logic [c_W-1:0]      w_word;
    logic [LOG2_TIN:0]   w_word_cnt;

    assign w_in_beat  = s_valid && s_ready;
    assign w_complete = w_in_beat && (s_last || (r_cnt == LOG2_TIN'(TIN - 1)));
    assign w_load     = w_complete || w_flush;
    assign w_word_cnt = {1'b0, r_cnt} + {{LOG2_TIN{1'b0}}, w_in_beat};

    // Lanes below cnt come from the fill buffer, lane cnt takes the current
    // beat (if any), everything above is forced to zero padding.
    always_comb begin
        w_word = '0;
        for (int j = 0; j < TIN; j++) begin
            if (j < int'(r_cnt)) begin
                w_word[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH] = r_fill[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH];
            end else if (j == int'(r_cnt) && w_in_beat) begin
                w_word[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH] = s_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (w_in_beat) begin
            r_fill[lane_lo(int'(r_cnt), DATA_WIDTH) +: DATA_WIDTH] <= s_dat;
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef TIN_PACK_FLUSH_TIMEOUT_EN
    localparam int c_IDLE_W = $clog2(FLUSH_CYCLES + 1);

    logic [c_IDLE_W-1:0] r_idle;
    logic                w_idle_cycle;

    // Fires in the FLUSH_CYCLES-th idle cycle; saturates while the slot is busy.
    assign w_idle_cycle = !w_in_beat && (r_cnt != '0);
    assign w_flush      = w_idle_cycle && s_ready && (r_idle >= c_IDLE_W'(FLUSH_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (!w_idle_cycle || w_flush) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_W'(FLUSH_CYCLES)) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    tin_pack_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .TIN        (TIN),
        .LOG2_TIN   (LOG2_TIN)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_dat (w_word),
        .load_cnt (w_word_cnt),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_dat    (m_dat),
        .m_cnt    (m_cnt),
        .s_ready  (s_ready)
    );

endmodule

`default_nettype wire
